sdram_port_arbiter: RTL and testbench

- Two-client arbiter and sequencer in front of the SDRAM controller top-level request interface (WR_REQ/RD_REQ, ACK, 22-bit address, 16-bit data).
- Shares the single SDRAM port between client A (e.g. capture/write path) and client B (e.g. display/readback path) with round-robin priority.
- Holds each request until acknowledged and handles read-data latency.
- Returns a single-cycle ACK, plus read data for reads, to the granted client.

---
 rtl/sdram_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of the SDRAM controller request port.
// Latency: client REQ sampled at edge n drives SDRAM_*_REQ from edge n; ACK pulses on the controller ACK edge (writes) or RD_LAT edges later (reads).
// Backpressure: requests are level-held until ACK; one transaction at a time, with at least one IDLE cycle between transactions.
// Optional: define SDRAM_ARB_TIMEOUT_EN to abandon a WAIT_ACK after TIMEOUT cycles and raise the sticky ERR flag.
module sdram_port_arbiter #(
  parameter int AW      = 22,
  parameter int DW      = 16,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic          CLK_100M,
  input  logic          RST,
  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_WDATA,
  output logic          A_ACK,
  output logic [DW-1:0] A_RDATA,
  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_WDATA,
  output logic          B_ACK,
  output logic [DW-1:0] B_RDATA,
  output logic          SDRAM_WR_REQ,
  output logic          SDRAM_RD_REQ,
  input  logic          SDRAM_WR_ACK,
  input  logic          SDRAM_RD_ACK,
  output logic [AW-1:0] SDRAM_ADDR_IN,
  output logic [DW-1:0] SDRAM_DATA_IN,
  input  logic [DW-1:0] SDRAM_DATA_OUT,
  output logic          BUSY,
  output logic          ERR
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RD_DLY   = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic          last_gnt;   // 0 = client A, 1 = client B
  logic          gnt;        // client owning the current transaction
  logic [3:0]    dly_cnt;

  logic          pick_b;
  logic          pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] to_cnt;
`else
  // Keeps the timeout parameter referenced when the feature is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign ERR = 1'b0;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    pick_b     = 1'b0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    if (A_REQ && B_REQ) pick_b = ~last_gnt;
    else                pick_b = B_REQ;
    pick_we    = pick_b ? B_WE    : A_WE;
    pick_addr  = pick_b ? B_ADDR  : A_ADDR;
    pick_wdata = pick_b ? B_WDATA : A_WDATA;
  end

  // Sequencer: grant, hold the controller request until its matching ACK, wait out read latency, then wait for ACK release.
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      last_gnt      <= 1'b1;
      gnt           <= 1'b0;
      dly_cnt       <= '0;
      A_ACK         <= 1'b0;
      B_ACK         <= 1'b0;
      A_RDATA       <= '0;
      B_RDATA       <= '0;
      SDRAM_WR_REQ  <= 1'b0;
      SDRAM_RD_REQ  <= 1'b0;
      SDRAM_ADDR_IN <= '0;
      SDRAM_DATA_IN <= '0;
      BUSY          <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_cnt        <= '0;
      ERR           <= 1'b0;
`endif
    end else begin
      A_ACK <= 1'b0;
      B_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (A_REQ || B_REQ) begin
            gnt           <= pick_b;
            last_gnt      <= pick_b;
            SDRAM_ADDR_IN <= pick_addr;
            SDRAM_DATA_IN <= pick_wdata;
            SDRAM_WR_REQ  <= pick_we;
            SDRAM_RD_REQ  <= ~pick_we;
            BUSY          <= 1'b1;
            state         <= WAIT_ACK;
`ifdef SDRAM_ARB_TIMEOUT_EN
            to_cnt        <= '0;
`endif
          end
        end
        WAIT_ACK: begin
          // Only the ACK matching the outstanding request type is honoured.
          if (SDRAM_WR_REQ && SDRAM_WR_ACK) begin
            SDRAM_WR_REQ <= 1'b0;
            if (gnt) B_ACK <= 1'b1;
            else     A_ACK <= 1'b1;
            state <= RELEASE;
          end else if (SDRAM_RD_REQ && SDRAM_RD_ACK) begin
            SDRAM_RD_REQ <= 1'b0;
            if (RD_LAT == 0) begin
              if (gnt) begin
                B_RDATA <= SDRAM_DATA_OUT;
                B_ACK   <= 1'b1;
              end else begin
                A_RDATA <= SDRAM_DATA_OUT;
                A_ACK   <= 1'b1;
              end
              state <= RELEASE;
            end else begin
              dly_cnt <= 4'(RD_LAT - 1);
              state   <= RD_DLY;
            end
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Abandon the request: the client is released without new read data.
            SDRAM_WR_REQ <= 1'b0;
            SDRAM_RD_REQ <= 1'b0;
            if (gnt) B_ACK <= 1'b1;
            else     A_ACK <= 1'b1;
            ERR   <= 1'b1;
            state <= RELEASE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RD_DLY: begin
          if (dly_cnt == 4'd0) begin
            if (gnt) begin
              B_RDATA <= SDRAM_DATA_OUT;
              B_ACK   <= 1'b1;
            end else begin
              A_RDATA <= SDRAM_DATA_OUT;
              A_ACK   <= 1'b1;
            end
            state <= RELEASE;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end
        RELEASE: begin
          // A level-style ACK must fall before the next grant so it is not counted twice.
          if (!SDRAM_WR_ACK && !SDRAM_RD_ACK) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int RD_LAT = 2;

  logic          CLK_100M, RST;
  logic          A_REQ, A_WE, A_ACK, B_REQ, B_WE, B_ACK;
  logic [AW-1:0] A_ADDR, B_ADDR, SDRAM_ADDR_IN;
  logic [DW-1:0] A_WDATA, B_WDATA, A_RDATA, B_RDATA, SDRAM_DATA_IN, SDRAM_DATA_OUT;
  logic          SDRAM_WR_REQ, SDRAM_RD_REQ, SDRAM_WR_ACK, SDRAM_RD_ACK, BUSY, ERR;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .TIMEOUT(8)) dut (
    .CLK_100M(CLK_100M), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_ACK(A_ACK), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_ACK(B_ACK), .B_RDATA(B_RDATA),
    .SDRAM_WR_REQ(SDRAM_WR_REQ), .SDRAM_RD_REQ(SDRAM_RD_REQ),
    .SDRAM_WR_ACK(SDRAM_WR_ACK), .SDRAM_RD_ACK(SDRAM_RD_ACK),
    .SDRAM_ADDR_IN(SDRAM_ADDR_IN), .SDRAM_DATA_IN(SDRAM_DATA_IN), .SDRAM_DATA_OUT(SDRAM_DATA_OUT),
    .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK_100M = 1'b0;
  always #5 CLK_100M = ~CLK_100M;

  task automatic tick();
    @(posedge CLK_100M);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_WDATA = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0;
    SDRAM_WR_ACK = 0; SDRAM_RD_ACK = 0; SDRAM_DATA_OUT = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1;
    tick(); tick();
    RST = 0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    tick(); tick();
    vectors++;
    if ({A_ACK, B_ACK, SDRAM_WR_REQ, SDRAM_RD_REQ, BUSY, ERR} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 000000", {A_ACK, B_ACK, SDRAM_WR_REQ, SDRAM_RD_REQ, BUSY, ERR});
    end
    vectors++;
    if (SDRAM_ADDR_IN !== '0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", SDRAM_ADDR_IN); end
    vectors++;
    if (SDRAM_DATA_IN !== '0) begin miscompares++; $display("FAIL reset_wdata got %h exp 0", SDRAM_DATA_IN); end
    vectors++;
    if ({A_RDATA, B_RDATA} !== '0) begin miscompares++; $display("FAIL reset_rdata got %h exp 0", {A_RDATA, B_RDATA}); end
    RST = 0;
  endtask

  task automatic test_single_write();
    int hi = 0;
    int b_seen = 0;
    apply_reset();
    A_REQ = 1; A_WE = 1; A_ADDR = 22'h00_1234; A_WDATA = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (SDRAM_WR_REQ) hi++;
      if (B_ACK || A_ACK) b_seen++;
      if (i == 0) begin
        vectors++;
        if (SDRAM_ADDR_IN !== 22'h00_1234 || SDRAM_DATA_IN !== 16'hBEEF || BUSY !== 1'b1 || SDRAM_RD_REQ !== 1'b0) begin
          miscompares++;
          $display("FAIL wr_latch got addr %h data %h busy %b rd %b exp 001234 beef 1 0", SDRAM_ADDR_IN, SDRAM_DATA_IN, BUSY, SDRAM_RD_REQ);
        end
      end
      if (i == 4) SDRAM_WR_ACK = 1;
    end
    tick();
    if (B_ACK) b_seen++;
    vectors++;
    if (SDRAM_WR_REQ !== 1'b0 || A_ACK !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ack_edge got req %b a_ack %b exp 0 1", SDRAM_WR_REQ, A_ACK);
    end
    SDRAM_WR_ACK = 0; A_REQ = 0;
    tick();
    if (B_ACK) b_seen++;
    vectors++;
    if (A_ACK !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_after got a_ack %b busy %b exp 0 0", A_ACK, BUSY);
    end
    vectors++;
    if (hi != 5) begin miscompares++; $display("FAIL wr_req_width got %0d exp 5", hi); end
    vectors++;
    if (b_seen != 0) begin miscompares++; $display("FAIL wr_stray_ack got %0d exp 0", b_seen); end
  endtask

  task automatic test_read_b();
    apply_reset();
    B_REQ = 1; B_WE = 0; B_ADDR = 22'h3F_FFFF;
    tick();
    vectors++;
    if (SDRAM_RD_REQ !== 1'b1 || SDRAM_WR_REQ !== 1'b0 || SDRAM_ADDR_IN !== 22'h3F_FFFF) begin
      miscompares++;
      $display("FAIL rd_grant got rd %b wr %b addr %h exp 1 0 3fffff", SDRAM_RD_REQ, SDRAM_WR_REQ, SDRAM_ADDR_IN);
    end
    SDRAM_RD_ACK = 1;
    tick();
    vectors++;
    if (SDRAM_RD_REQ !== 1'b0 || B_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_ack_edge got req %b b_ack %b exp 0 0", SDRAM_RD_REQ, B_ACK);
    end
    SDRAM_RD_ACK = 0; SDRAM_DATA_OUT = 16'h1111;
    tick();
    vectors++;
    if (B_ACK !== 1'b0) begin miscompares++; $display("FAIL rd_early_ack got %b exp 0", B_ACK); end
    SDRAM_DATA_OUT = 16'h5A5A;
    tick();
    vectors++;
    if (B_ACK !== 1'b1 || B_RDATA !== 16'h5A5A || A_ACK !== 1'b0 || A_RDATA !== 16'h0000) begin
      miscompares++;
      $display("FAIL rd_data got b_ack %b b_rdata %h a_ack %b a_rdata %h exp 1 5a5a 0 0000", B_ACK, B_RDATA, A_ACK, A_RDATA);
    end
    SDRAM_DATA_OUT = 16'h0000; B_REQ = 0;
    tick();
    vectors++;
    if (B_ACK !== 1'b0 || B_RDATA !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL rd_hold got b_ack %b b_rdata %h exp 0 5a5a", B_ACK, B_RDATA);
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_addr [4];
    logic [1:0]    exp_ack  [4];
    int last_ack = -100;
    exp_addr = '{22'h0000A1, 22'h0000B2, 22'h0000A1, 22'h0000B2};
    exp_ack  = '{2'b10, 2'b01, 2'b10, 2'b01};
    apply_reset();
    A_REQ = 1; A_WE = 1; A_ADDR = 22'h0000A1; A_WDATA = 16'h00A1;
    B_REQ = 1; B_WE = 1; B_ADDR = 22'h0000B2; B_WDATA = 16'h00B2;
    for (int t = 0; t < 4; t++) begin
      int w = 0;
      while (!SDRAM_WR_REQ && w < 20) begin tick(); w++; end
      vectors++;
      if (w >= 20) begin
        miscompares++;
        $display("FAIL cont_wait got timeout exp wr_req txn %0d", t);
      end else if (SDRAM_ADDR_IN !== exp_addr[t]) begin
        miscompares++;
        $display("FAIL cont_order got addr %h exp %h txn %0d", SDRAM_ADDR_IN, exp_addr[t], t);
      end
      SDRAM_WR_ACK = 1;
      tick();
      SDRAM_WR_ACK = 0;
      vectors++;
      if ({A_ACK, B_ACK} !== exp_ack[t]) begin
        miscompares++;
        $display("FAIL cont_ack got %b exp %b txn %0d", {A_ACK, B_ACK}, exp_ack[t], t);
      end
      if (t > 0) begin
        vectors++;
        if (cyc - last_ack < 2) begin
          miscompares++;
          $display("FAIL cont_gap got %0d exp >=2", cyc - last_ack);
        end
      end
      last_ack = cyc;
    end
    A_REQ = 0; B_REQ = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_level_ack();
    int pulses = 0;
    apply_reset();
    A_REQ = 1; A_WE = 1; A_ADDR = 22'h000005; A_WDATA = 16'h0005;
    tick();
    vectors++;
    if (SDRAM_WR_REQ !== 1'b1) begin miscompares++; $display("FAIL lvl_grant got %b exp 1", SDRAM_WR_REQ); end
    SDRAM_WR_ACK = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) A_REQ = 0;
      if (A_ACK) pulses++;
      if (i < 3) begin
        vectors++;
        if (BUSY !== 1'b1) begin miscompares++; $display("FAIL lvl_busy got %b exp 1 step %0d", BUSY, i); end
      end
      if (i == 2) SDRAM_WR_ACK = 0;
      if (i == 3) begin
        vectors++;
        if (BUSY !== 1'b0) begin miscompares++; $display("FAIL lvl_release got %b exp 0", BUSY); end
      end
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL lvl_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_reset_mid_read();
    int w = 0;
    apply_reset();
    A_REQ = 1; A_WE = 0; A_ADDR = 22'h2A_BCDE;
    tick();
    SDRAM_RD_ACK = 1;
    tick();
    SDRAM_RD_ACK = 0;
    vectors++;
    if (BUSY !== 1'b1 || SDRAM_ADDR_IN !== 22'h2A_BCDE) begin
      miscompares++;
      $display("FAIL rst_pre got busy %b addr %h exp 1 2abcde", BUSY, SDRAM_ADDR_IN);
    end
    #2 RST = 1;
    #1;
    vectors++;
    if ({A_ACK, B_ACK, SDRAM_WR_REQ, SDRAM_RD_REQ, BUSY, ERR} !== 6'b0 || SDRAM_ADDR_IN !== '0) begin
      miscompares++;
      $display("FAIL rst_async got ctrl %b addr %h exp 000000 0", {A_ACK, B_ACK, SDRAM_WR_REQ, SDRAM_RD_REQ, BUSY, ERR}, SDRAM_ADDR_IN);
    end
    tick();
    RST = 0;
    B_REQ = 1; B_WE = 0; B_ADDR = 22'h11_1111;
    while (!SDRAM_RD_REQ && w < 20) begin tick(); w++; end
    vectors++;
    if (w >= 20 || SDRAM_ADDR_IN !== 22'h2A_BCDE) begin
      miscompares++;
      $display("FAIL rst_regrant got addr %h wait %0d exp 2abcde", SDRAM_ADDR_IN, w);
    end
    SDRAM_RD_ACK = 1;
    tick();
    SDRAM_RD_ACK = 0; SDRAM_DATA_OUT = 16'h0F0F;
    tick();
    SDRAM_DATA_OUT = 16'hC3C3;
    tick();
    vectors++;
    if (A_ACK !== 1'b1 || A_RDATA !== 16'hC3C3 || B_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_read got a_ack %b a_rdata %h b_ack %b exp 1 c3c3 0", A_ACK, A_RDATA, B_ACK);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int hi = 0;
    int low_step = -1;
    int ack_step = -1;
    apply_reset();
    A_REQ = 1; A_WE = 1; A_ADDR = 22'h000007; A_WDATA = 16'h0007;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (SDRAM_WR_REQ) hi++;
      else if (low_step < 0) low_step = i;
      if (A_ACK && ack_step < 0) ack_step = i;
      if (A_ACK) A_REQ = 0;
    end
`ifdef SDRAM_ARB_TIMEOUT_EN
    vectors++;
    if (hi != 8 || low_step != 8) begin
      miscompares++;
      $display("FAIL to_req_width got %0d low %0d exp 8 8", hi, low_step);
    end
    vectors++;
    if (ack_step != 8) begin miscompares++; $display("FAIL to_ack got step %0d exp 8", ack_step); end
    vectors++;
    if (ERR !== 1'b1 || A_ACK !== 1'b0) begin
      miscompares++;
      $display("FAIL to_err got err %b a_ack %b exp 1 0", ERR, A_ACK);
    end
`else
    vectors++;
    if (hi != 20 || SDRAM_WR_REQ !== 1'b1) begin
      miscompares++;
      $display("FAIL to_hold got %0d req %b exp 20 1", hi, SDRAM_WR_REQ);
    end
    vectors++;
    if (ERR !== 1'b0 || ack_step != -1) begin
      miscompares++;
      $display("FAIL to_noerr got err %b ack_step %0d exp 0 -1", ERR, ack_step);
    end
`endif
    apply_reset();
  endtask

  // Transaction-level model: round-robin on the sampled requests, one outstanding transaction,
  // read data equals what the controller model returned, the idle client's data never moves.
  task automatic test_random();
    logic          c_req [2];
    logic          c_we  [2];
    logic [AW-1:0] c_addr[2];
    logic [DW-1:0] c_wd  [2];
    logic          p_req [2];
    logic          p_we  [2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_wd  [2];
    logic [DW-1:0] m_rdata[2];
    logic          m_last_b = 1'b1;
    bit            out_vld = 0;
    int            out_c = 0;
    bit            out_we = 0;
    bit            ctl_busy = 0, ctl_rd = 0, ctl_started = 0;
    int            ctl_dly = 0, ctl_hold = 0, data_cnt = -1;
    logic [DW-1:0] ctl_data = '0;
    int            done = 0;
    int            acked;
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      c_req[c] = 0; c_we[c] = 0; c_addr[c] = '0; c_wd[c] = '0; m_rdata[c] = '0;
    end
    for (int step = 0; step < 8000 && done < 200; step++) begin
      for (int c = 0; c < 2; c++) begin
        p_req[c] = c_req[c]; p_we[c] = c_we[c]; p_addr[c] = c_addr[c]; p_wd[c] = c_wd[c];
      end
      tick();
      acked = -1;
      if ((SDRAM_WR_REQ || SDRAM_RD_REQ) && !out_vld) begin
        int w;
        if (p_req[0] && p_req[1]) w = m_last_b ? 0 : 1;
        else if (p_req[1])        w = 1;
        else                      w = 0;
        vectors++;
        if (!p_req[w] || SDRAM_ADDR_IN !== p_addr[w] || SDRAM_WR_REQ !== p_we[w] || SDRAM_RD_REQ !== !p_we[w] ||
            (p_we[w] && SDRAM_DATA_IN !== p_wd[w])) begin
          miscompares++;
          $display("FAIL rnd_grant got addr %h wr %b rd %b data %h exp client %0d addr %h we %b data %h",
                   SDRAM_ADDR_IN, SDRAM_WR_REQ, SDRAM_RD_REQ, SDRAM_DATA_IN, w, p_addr[w], p_we[w], p_wd[w]);
        end
        m_last_b = (w == 1);
        out_vld = 1; out_c = w; out_we = p_we[w];
      end
      if (A_ACK || B_ACK) begin
        logic [DW-1:0] got_rd;
        got_rd = (out_c == 1) ? B_RDATA : A_RDATA;
        vectors++;
        if (!out_vld || {A_ACK, B_ACK} !== ((out_c == 1) ? 2'b01 : 2'b10)) begin
          miscompares++;
          $display("FAIL rnd_ack got %b exp client %0d outstanding %0d", {A_ACK, B_ACK}, out_c, out_vld);
        end else begin
          if (!out_we) m_rdata[out_c] = ctl_data;
          vectors++;
          if (got_rd !== m_rdata[out_c] || ((out_c == 1) ? A_RDATA : B_RDATA) !== m_rdata[1 - out_c]) begin
            miscompares++;
            $display("FAIL rnd_rdata got a %h b %h exp a %h b %h", A_RDATA, B_RDATA, m_rdata[0], m_rdata[1]);
          end
          acked = out_c;
          done++;
        end
        out_vld = 0;
      end
      // Controller: random delay, then a 1..3 cycle level ACK; read data RD_LAT cycles after the first ACK cycle.
      if (!ctl_busy && (SDRAM_WR_REQ || SDRAM_RD_REQ)) begin
        ctl_busy = 1; ctl_rd = SDRAM_RD_REQ; ctl_started = 0;
        ctl_dly = $urandom_range(0, 3); ctl_hold = $urandom_range(1, 3);
      end
      SDRAM_WR_ACK = 0; SDRAM_RD_ACK = 0;
      if (ctl_busy) begin
        if (ctl_dly > 0) ctl_dly--;
        else if (ctl_hold > 0) begin
          if (!ctl_started) begin
            ctl_started = 1;
            if (ctl_rd) begin data_cnt = RD_LAT; ctl_data = DW'($urandom); end
          end
          if (ctl_rd) SDRAM_RD_ACK = 1; else SDRAM_WR_ACK = 1;
          ctl_hold--;
        end else ctl_busy = 0;
      end
      if (data_cnt == 0) begin
        SDRAM_DATA_OUT = ctl_data; data_cnt = -1;
      end else begin
        if (data_cnt > 0) data_cnt--;
        SDRAM_DATA_OUT = DW'($urandom);
      end
      for (int c = 0; c < 2; c++) begin
        if (acked == c) begin
          c_req[c] = ($urandom_range(0, 1) == 1);
          c_we[c] = ($urandom_range(0, 1) == 1); c_addr[c] = AW'($urandom); c_wd[c] = DW'($urandom);
        end else if (!c_req[c] && $urandom_range(0, 2) == 0) begin
          c_req[c] = 1;
          c_we[c] = ($urandom_range(0, 1) == 1); c_addr[c] = AW'($urandom); c_wd[c] = DW'($urandom);
        end
      end
      A_REQ = c_req[0]; A_WE = c_we[0]; A_ADDR = c_addr[0]; A_WDATA = c_wd[0];
      B_REQ = c_req[1]; B_WE = c_we[1]; B_ADDR = c_addr[1]; B_WDATA = c_wd[1];
    end
    vectors++;
    if (done < 200) begin miscompares++; $display("FAIL rnd_progress got %0d exp 200", done); end
    idle_inputs();
  endtask

  initial begin
    RST = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_read_b();
    test_contention();
    test_level_ack();
    test_reset_mid_read();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
